alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Pipelined, multi-cycle-aware ALU control unit for the LEGv8 datapath; sits on the ID/EX boundary.
- Decodes the 11-bit opcode and the 2-bit ALUOp from main control into a registered 4-bit ALU control word.
- Tracks multi-cycle EX operations (MUL, optionally shifts) with a down-counter.
- Provides a valid/ready handshake toward ID, and honours stall/flush from the hazard unit.

Parameters:
- MUL_CYCLES, 4: EX cycles occupied by MUL; must be at least 1.
- SHIFT_CYCLES, 1: EX cycles occupied by LSL/LSR; 1 means single-cycle.
- CNT_W, 4: width of the occupancy counter; must satisfy 2^CNT_W > max(MUL_CYCLES, SHIFT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage presents an instruction
- id_ready  out  1  unit accepts this cycle
- id_opcode  in  11  instruction[31:21]
- id_aluop  in  2  ALUOp from main control
- ex_stall  in  1  downstream hold; all EX state frozen
- flush  in  1  synchronous kill of EX contents
- ex_valid  out  1  ex_ctrl is live
- ex_ctrl  out  4  ALU operation select
- ex_multi  out  1  a multi-cycle op occupies EX
- illegal  out  1  registered flag: undecodable R-type

Behaviour:
- Reset (async): ex_valid=0, ex_ctrl=4'b0000, ex_multi=0, illegal=0, state=IDLE, cnt=0.
- Decode, combinational, internal only:
  - ALUOp 00 -> 0000.
  - ALUOp 01 -> 0111.
  - ALUOp 11 -> 1000.
  - ALUOp 10, by opcode:
    - ADDS 1368 -> 0010
    - SUBS 1880 -> 0011
    - LSL 1691 -> 1001
    - LSR 1690 -> 1010
    - ADDI 1160/1161 -> 0010
    - LDUR 1986, STUR 1984 -> 0010
    - MUL 1240 -> 1011
    - anything else -> 1111 with illegal set.
- id_ready = !flush && !ex_stall && (state==IDLE).
  - The ready decision is registered-state based; it does not depend combinationally on id_valid.
- Accept = id_valid && id_ready. On accept, next edge:
  - ex_valid<=1, ex_ctrl<=decode, illegal<=decode_illegal.
  - Latency is 1 cycle.
- Multi-cycle entry:
  - If the accepted op has occupancy N>1 (MUL_CYCLES, or SHIFT_CYCLES for LSL/LSR), then state<=MULTI and cnt<=N-1.
  - ex_multi=1 for the whole MULTI residence.
- States: IDLE and MULTI.
  - IDLE -> MULTI on accept of an op with N>1.
  - MULTI: decrement cnt on each non-stalled cycle. When cnt==1 and !ex_stall, go to IDLE next edge.
  - While in MULTI: ex_valid=1 and ex_ctrl hold the op; illegal=0 after its first cycle.
  - Total EX residency is exactly N cycles, excluding stalls.
- No accept, IDLE, !ex_stall: ex_valid<=0 (bubble), ex_ctrl holds, illegal<=0.
- ex_stall=1 (and flush=0): every register holds, including cnt.
- flush=1: highest priority over stall and accept.
  - Next edge: ex_valid=0, illegal=0, ex_multi=0, state=IDLE, cnt=0.
  - The ID instruction in the same cycle is not accepted.
- Reset mid-MULTI: immediate return to reset values; no residual occupancy.
- MUL_CYCLES=1 and SHIFT_CYCLES=1: the unit never enters MULTI, and id_ready tracks !ex_stall && !flush.

Optional Feature:
- Macro ALU_CTRL_PERF_EN.
- Defined:
  - Adds 16-bit saturating outputs perf_issued (accepts) and perf_busy (cycles with id_valid=1 and id_ready=0).
  - Both clear on reset, are unaffected by flush, and saturate at 16'hFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg holds:
  - Opcode constants: OPC_ADDS, OPC_SUBS, OPC_LSL, OPC_LSR, OPC_ADDI0/1, OPC_LDUR, OPC_STUR, OPC_MUL.
  - ALU control codes: ALU_ADD=0000, ALU_ADDS=0010, ALU_SUBS=0011, ALU_PASSB=0111, ALU_MOVK=1000, ALU_LSL=1001, ALU_LSR=1010, ALU_MUL=1011, ALU_ILL=1111.
  - ALUOp encodings.
  - State enum {IDLE, MULTI}.
- One sub-module: alu_ctrl_dec, purely combinational (opcode, aluop -> ctrl, illegal, occupancy).
- The top level holds the FSM, counter and registers.

Test Plan:
- Reset, then ADDS (aluop=10, opc=1368) with id_valid=1 -> one cycle later ex_valid=1, ex_ctrl=0010; id_ready stays 1.
- MUL (opc=1240), MUL_CYCLES=4 -> ex_ctrl=1011, ex_multi=1 for 4 cycles, id_ready=0 for cycles 1-3, back to 1 on cycle 4; a following SUBS lands with ex_ctrl=0011 on cycle 5.
- MUL accepted, ex_stall=1 for 2 cycles in the middle -> MULTI lasts 6 cycles; ex_ctrl holds 1011 throughout.
- MUL in MULTI with cnt=2, flush=1 -> next cycle ex_valid=0, ex_multi=0, id_ready=1; the simultaneous ID instruction is dropped.
- aluop=10, opc=1234 -> ex_ctrl=1111, illegal=1 for exactly one cycle; aluop=01 -> 0111; aluop=11 -> 1000.
- reset asserted mid-MULTI, asynchronously between edges -> outputs go to reset values immediately; with ALU_CTRL_PERF_EN defined, perf_issued=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// LEGv8 ALU control constants: opcodes, ALUOp encodings, ALU select codes, FSM encoding.
// Shared by the decoder and the EX sequencer.
package alu_ctrl_pkg;

  localparam logic [10:0] OPC_ADDS  = 11'd1368;
  localparam logic [10:0] OPC_SUBS  = 11'd1880;
  localparam logic [10:0] OPC_LSL   = 11'd1691;
  localparam logic [10:0] OPC_LSR   = 11'd1690;
  localparam logic [10:0] OPC_ADDI0 = 11'd1160;
  localparam logic [10:0] OPC_ADDI1 = 11'd1161;
  localparam logic [10:0] OPC_LDUR  = 11'd1986;
  localparam logic [10:0] OPC_STUR  = 11'd1984;
  localparam logic [10:0] OPC_MUL   = 11'd1240;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_MOVK  = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_ADDS  = 4'b0010;
  localparam logic [3:0] ALU_SUBS  = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MOVK  = 4'b1000;
  localparam logic [3:0] ALU_LSL   = 4'b1001;
  localparam logic [3:0] ALU_LSR   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1011;
  localparam logic [3:0] ALU_ILL   = 4'b1111;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t MULTI = 1'b1;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: (opcode, aluop) -> ctrl word, illegal flag, EX occupancy.
// No state, no latency; occupancy is 1 for everything except MUL and the shifts.
import alu_ctrl_pkg::*;

module alu_ctrl_dec #(
  parameter int MUL_CYCLES   = 4,
  parameter int SHIFT_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic [10:0]      opcode,
  input  logic [1:0]       aluop,
  output logic [3:0]       ctrl,
  output logic             illegal,
  output logic [CNT_W-1:0] occ
);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    occ     = CNT_W'(1);
    case (aluop)
      ALUOP_LDST: ctrl = ALU_ADD;
      ALUOP_CBZ:  ctrl = ALU_PASSB;
      ALUOP_MOVK: ctrl = ALU_MOVK;
      default: begin
        case (opcode)
          OPC_ADDS:  ctrl = ALU_ADDS;
          OPC_SUBS:  ctrl = ALU_SUBS;
          OPC_LSL: begin
            ctrl = ALU_LSL;
            occ  = CNT_W'(SHIFT_CYCLES);
          end
          OPC_LSR: begin
            ctrl = ALU_LSR;
            occ  = CNT_W'(SHIFT_CYCLES);
          end
          OPC_ADDI0, OPC_ADDI1, OPC_LDUR, OPC_STUR: ctrl = ALU_ADDS;
          OPC_MUL: begin
            ctrl = ALU_MUL;
            occ  = CNT_W'(MUL_CYCLES);
          end
          default: begin
            ctrl    = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ID/EX ALU control register with multi-cycle occupancy tracking; 1-cycle latency, id_ready low while
// a multi-cycle op is busy, on ex_stall or on flush. Optional perf counters under ALU_CTRL_PERF_EN.
import alu_ctrl_pkg::*;

module alu_ctrl_seq #(
  parameter int MUL_CYCLES   = 4,
  parameter int SHIFT_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [10:0] id_opcode,
  input  logic [1:0]  id_aluop,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_ctrl,
  output logic        ex_multi,
  output logic        illegal
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_busy
`endif
);

  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  logic [CNT_W-1:0] dec_occ;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             accept;

  alu_ctrl_dec #(
    .MUL_CYCLES  (MUL_CYCLES),
    .SHIFT_CYCLES(SHIFT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dec (
    .opcode (id_opcode),
    .aluop  (id_aluop),
    .ctrl   (dec_ctrl),
    .illegal(dec_illegal),
    .occ    (dec_occ)
  );

  assign id_ready = !flush && !ex_stall && (state == IDLE);
  assign accept   = id_valid && id_ready;

  // MULTI covers cycles 1..N-1 of the op; cycle N is back in IDLE so the next op can overlap,
  // which is why ex_multi is a register that stays set across that last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= ALU_ADD;
      ex_multi <= 1'b0;
      illegal  <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_multi <= 1'b0;
      illegal  <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (state == MULTI) begin
      illegal <= 1'b0;
      cnt     <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state <= IDLE;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec_ctrl;
      illegal  <= dec_illegal;
      ex_multi <= (dec_occ > CNT_W'(1));
      if (dec_occ > CNT_W'(1)) begin
        state <= MULTI;
        cnt   <= dec_occ - CNT_W'(1);
      end
    end else begin
      ex_valid <= 1'b0;
      ex_multi <= 1'b0;
      illegal  <= 1'b0;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued <= '0;
      perf_busy   <= '0;
    end else begin
      if (accept && perf_issued != 16'hFFFF) perf_issued <= perf_issued + 16'd1;
      if (id_valid && !id_ready && perf_busy != 16'hFFFF) perf_busy <= perf_busy + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with default parameters (MUL_CYCLES=4, SHIFT_CYCLES=1).
// Inputs change 2 time units after a rising edge; outputs are sampled there too.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [10:0] id_opcode;
  logic [1:0]  id_aluop;
  logic        ex_stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_ctrl;
  logic        ex_multi;
  logic        illegal;
`ifdef ALU_CTRL_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_busy;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk      (clk),
    .reset    (reset),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_opcode(id_opcode),
    .id_aluop (id_aluop),
    .ex_stall (ex_stall),
    .flush    (flush),
    .ex_valid (ex_valid),
    .ex_ctrl  (ex_ctrl),
    .ex_multi (ex_multi),
    .illegal  (illegal)
`ifdef ALU_CTRL_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_busy  (perf_busy)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc);
    id_valid  = v;
    id_aluop  = op;
    id_opcode = opc;
  endtask

  initial begin
    reset = 1'b1;
    ex_stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 11'd0);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 4'b0000);
    chk("rst_ex_multi", ex_multi, 0);
    chk("rst_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_id_ready", id_ready, 1);

    // ADDS, single cycle
    drive(1'b1, 2'b10, 11'd1368);
    tick();
    chk("adds_valid", ex_valid, 1);
    chk("adds_ctrl", ex_ctrl, 4'b0010);
    chk("adds_ready", id_ready, 1);
    chk("adds_multi", ex_multi, 0);

    // MUL occupies 4 cycles, SUBS waits and lands on cycle 5
    drive(1'b1, 2'b10, 11'd1240);
    tick();
    drive(1'b1, 2'b10, 11'd1880);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("mul_c%0d_multi", i), ex_multi, 1);
      chk($sformatf("mul_c%0d_ctrl", i), ex_ctrl, 4'b1011);
      chk($sformatf("mul_c%0d_ready", i), id_ready, (i == 4) ? 16'd1 : 16'd0);
      if (i < 4) tick();
    end
    tick();
    chk("subs_ctrl", ex_ctrl, 4'b0011);
    chk("subs_valid", ex_valid, 1);
    chk("subs_multi", ex_multi, 0);
    drive(1'b0, 2'b10, 11'd1880);
    tick();
    chk("bubble_valid", ex_valid, 0);
    chk("bubble_ctrl_hold", ex_ctrl, 4'b0011);

    // MUL with a 2-cycle stall in the middle: 6 cycles of occupancy
    drive(1'b1, 2'b10, 11'd1240);
    tick();
    drive(1'b0, 2'b10, 11'd1240);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("stl_c%0d_multi", i), ex_multi, 1);
      chk($sformatf("stl_c%0d_ctrl", i), ex_ctrl, 4'b1011);
      chk($sformatf("stl_c%0d_valid", i), ex_valid, 1);
      if (i == 2) ex_stall = 1'b1;
      if (i == 4) ex_stall = 1'b0;
      tick();
    end
    chk("stl_end_multi", ex_multi, 0);
    chk("stl_end_valid", ex_valid, 0);

    // flush while MUL has cnt=2; the concurrent ADDS is dropped
    drive(1'b1, 2'b10, 11'd1240);
    tick();
    drive(1'b0, 2'b10, 11'd1240);
    tick();
    flush = 1'b1;
    drive(1'b1, 2'b10, 11'd1368);
    #1 chk("fl_ready_low", id_ready, 0);
    tick();
    chk("fl_valid", ex_valid, 0);
    chk("fl_multi", ex_multi, 0);
    chk("fl_ctrl_hold", ex_ctrl, 4'b1011);
    flush = 1'b0;
    drive(1'b0, 2'b10, 11'd1368);
    #1 chk("fl_ready", id_ready, 1);

    // illegal R-type and the other ALUOp / opcode rows
    drive(1'b1, 2'b10, 11'd1234);
    tick();
    chk("ill_ctrl", ex_ctrl, 4'b1111);
    chk("ill_flag", illegal, 1);
    drive(1'b1, 2'b01, 11'd1234);
    tick();
    chk("cbz_ctrl", ex_ctrl, 4'b0111);
    chk("ill_cleared", illegal, 0);
    drive(1'b1, 2'b11, 11'd0);
    tick();
    chk("movk_ctrl", ex_ctrl, 4'b1000);
    drive(1'b1, 2'b00, 11'd1986);
    tick();
    chk("ldst_ctrl", ex_ctrl, 4'b0000);
    drive(1'b1, 2'b10, 11'd1691);
    tick();
    chk("lsl_ctrl", ex_ctrl, 4'b1001);
    chk("lsl_single", ex_multi, 0);
    chk("lsl_ready", id_ready, 1);
    drive(1'b1, 2'b10, 11'd1690);
    tick();
    chk("lsr_ctrl", ex_ctrl, 4'b1010);
    drive(1'b1, 2'b10, 11'd1161);
    tick();
    chk("addi_ctrl", ex_ctrl, 4'b0010);
    drive(1'b1, 2'b10, 11'd1984);
    tick();
    chk("stur_ctrl", ex_ctrl, 4'b0010);
    chk("stur_illegal", illegal, 0);

    // asynchronous reset in the middle of MULTI
    drive(1'b1, 2'b10, 11'd1240);
    tick();
    drive(1'b0, 2'b10, 11'd1240);
    tick();
    chk("ar_pre_multi", ex_multi, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", ex_valid, 0);
    chk("ar_ctrl", ex_ctrl, 4'b0000);
    chk("ar_multi", ex_multi, 0);
    chk("ar_ready", id_ready, 1);
`ifdef ALU_CTRL_PERF_EN
    chk("ar_perf_issued", perf_issued, 16'd0);
    chk("ar_perf_busy", perf_busy, 16'd0);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("ar_after_valid", ex_valid, 0);
    chk("ar_after_multi", ex_multi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
